// File: rtl/example_prod_accum.sv
// example_prod_accum: sums N_TERMS signed products per output vector, then
// applies an arithmetic right shift and saturates to a signed OUT_WIDTH result.
//
// Handshake semantics (both ports): a transfer happens on a rising ap_clk edge
// where valid && ready are both high. A source holds data stable while valid is
// high and ready is low. prod_ready is a combinational function of out_valid
// and out_ready only, never of prod_valid, so no combinational loop can form
// through this block.
module example_prod_accum #(
    parameter int N_TERMS    = 4,
    parameter int PROD_WIDTH = 20,
    parameter int ACC_WIDTH  = 27,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         dbg_state_o,
    output logic [6:0]                   dbg_cnt_o
);

    // Counter needs at least one bit even when every product is a full vector.
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    // Saturation bounds expressed at accumulator width so the compare is exact.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // ACC: collecting terms, no result pending. FULL: result held on out_*.
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [OUT_WIDTH-1:0]  out_data_q;
    logic signed [OUT_WIDTH-1:0]  out_data_d;
    logic                         out_sat_q;
    logic                         out_sat_d;
    logic                         out_valid_q;

    logic                         prod_hs;
    logic                         out_hs;
    logic                         last_term;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_base;
    logic signed [ACC_WIDTH-1:0]  shifted;

    // Input is accepted whenever the output slot is empty or being drained now.
    assign prod_ready = !out_valid_q || out_ready;
    assign prod_hs    = prod_valid && prod_ready;
    assign out_hs     = out_valid_q && out_ready;
    assign last_term  = (cnt_q == LAST_CNT);

    // Next accumulator/counter values and the shifted, saturated candidate result.
    always_comb begin
        prod_ext   = ACC_WIDTH'(prod_data);
        acc_base   = (cnt_q == '0) ? '0 : acc_q;
        acc_d      = acc_base + prod_ext;
        cnt_d      = last_term ? '0 : cnt_q + CNT_W'(1);
        shifted    = acc_d >>> SHIFT;
        out_data_d = shifted[OUT_WIDTH-1:0];
        out_sat_d  = 1'b0;
        if (shifted > SAT_MAX) begin
            out_data_d = OUT_MAX;
            out_sat_d  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            out_data_d = OUT_MIN;
            out_sat_d  = 1'b1;
        end
    end

    // Control FSM plus datapath registers; a new final term may replace a
    // result in the same cycle it is being handed downstream.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (prod_hs) begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
            case (state_q)
                ST_ACC: begin
                    if (prod_hs && last_term) begin
                        state_q     <= ST_FULL;
                        out_valid_q <= 1'b1;
                        out_data_q  <= out_data_d;
                        out_sat_q   <= out_sat_d;
                    end
                end
                ST_FULL: begin
                    if (prod_hs && last_term) begin
                        state_q     <= ST_FULL;
                        out_valid_q <= 1'b1;
                        out_data_q  <= out_data_d;
                        out_sat_q   <= out_sat_d;
                    end else if (out_hs) begin
                        state_q     <= ST_ACC;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_ACC;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign out_valid   = out_valid_q;
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = 7'(cnt_q);

endmodule

// File: tb/tb_example_prod_accum.sv
// Bench for example_prod_accum: three instances (4 terms/shift 0, 4 terms/shift 2,
// 1 term/shift 0) driven by table vectors, hand sequences and random vectors.
module tb_example_prod_accum;

    localparam int PW = 20;
    localparam int OW = 16;

    typedef struct {
        int u;
        int n;
        int p0;
        int p1;
        int p2;
        int p3;
        int ed;
        bit es;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [PW-1:0] prod_data [3];
    logic                 prod_valid [3];
    logic                 prod_ready [3];
    logic signed [OW-1:0] out_data [3];
    logic                 out_sat [3];
    logic                 out_valid [3];
    logic                 out_ready [3];
    logic                 dbg_state [3];
    logic [6:0]           dbg_cnt [3];

    logic [OW:0] exp_q0[$];
    logic [OW:0] exp_q1[$];
    logic [OW:0] exp_q2[$];
    int          pop_cyc0[$];
    vec_t        vecs[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit bp_en = 1'b0;

    example_prod_accum #(.N_TERMS(4), .SHIFT(0)) u0 (
        .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data[0]), .prod_valid(prod_valid[0]),
        .prod_ready(prod_ready[0]), .out_data(out_data[0]), .out_sat(out_sat[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dbg_state_o(dbg_state[0]),
        .dbg_cnt_o(dbg_cnt[0]));

    example_prod_accum #(.N_TERMS(4), .SHIFT(2)) u1 (
        .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data[1]), .prod_valid(prod_valid[1]),
        .prod_ready(prod_ready[1]), .out_data(out_data[1]), .out_sat(out_sat[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dbg_state_o(dbg_state[1]),
        .dbg_cnt_o(dbg_cnt[1]));

    example_prod_accum #(.N_TERMS(1), .SHIFT(0)) u2 (
        .ap_clk(clk), .ap_rst(rst), .prod_data(prod_data[2]), .prod_valid(prod_valid[2]),
        .prod_ready(prod_ready[2]), .out_data(out_data[2]), .out_sat(out_sat[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .dbg_state_o(dbg_state[2]),
        .dbg_cnt_o(dbg_cnt[2]));

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(int u, logic [OW:0] e);
        case (u)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    // Pops the oldest expected result for unit u and compares it with the DUT.
    task automatic pop_check(int u);
        logic [OW:0] e;
        logic [OW:0] a;
        bit got;
        got = 1'b0;
        e = '0;
        a = {out_sat[u], out_data[u]};
        case (u)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); got = 1'b1; end
        endcase
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL out_u%0d unexpected result data=%0d sat=%0d", u, out_data[u], out_sat[u]);
        end else if (a !== e) begin
            failures++;
            $display("FAIL out_u%0d got data=%0d sat=%0d expected data=%0d sat=%0d",
                     u, $signed(a[OW-1:0]), a[OW], $signed(e[OW-1:0]), e[OW]);
        end
    endtask

    // Drives one product and returns right after the edge it was accepted on.
    task automatic send(int u, int v);
        int guard;
        bit rdy;
        guard = 0;
        prod_data[u] = PW'(v);
        prod_valid[u] = 1'b1;
        forever begin
            @(negedge clk);
            rdy = prod_ready[u];
            @(posedge clk);
            #1;
            if (rdy) break;
            guard++;
            if (guard > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout_u%0d value=%0d", u, v);
                break;
            end
        end
        prod_valid[u] = 1'b0;
    endtask

    task automatic add_vec(int u, int n, int p0, int p1, int p2, int p3, int ed, bit es);
        vec_t v;
        v.u = u; v.n = n; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.ed = ed; v.es = es;
        vecs.push_back(v);
    endtask

    function automatic logic [OW:0] model(int sum, int sh);
        int s;
        logic [OW:0] r;
        s = sum >>> sh;
        if (s > 32767) r = {1'b1, 16'h7fff};
        else if (s < -32768) r = {1'b1, 16'h8000};
        else r = {1'b0, s[15:0]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int sum;
        int pv;
        int sh;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prod_data[i] = '0;
            prod_valid[i] = 1'b0;
            out_ready[i] = 1'b1;
        end

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                for (int u = 0; u < 3; u++) begin
                    if (out_valid[u] && out_ready[u]) begin
                        if (u == 0) pop_cyc0.push_back(cyc);
                        pop_check(u);
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                if (bp_en) begin
                    out_ready[0] = 1'($urandom_range(0, 1));
                    out_ready[1] = 1'($urandom_range(0, 1));
                end
            end
            begin
                #400000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        #2;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_out_valid_u%0d", u), out_valid[u], 0);
            chk($sformatf("rst_out_data_u%0d", u), out_data[u], 0);
            chk($sformatf("rst_out_sat_u%0d", u), out_sat[u], 0);
            chk($sformatf("rst_prod_ready_u%0d", u), prod_ready[u], 1);
            chk($sformatf("rst_cnt_u%0d", u), dbg_cnt[u], 0);
        end
        tick();
        tick();
        rst = 1'b0;

        // Table of vectors, applied back-to-back per unit
        add_vec(0, 4, 100, -50, 25, 5, 80, 0);
        add_vec(0, 4, 20000, 20000, 20000, 20000, 32767, 1);
        add_vec(0, 4, -516096, -516096, -516096, -516096, -32768, 1);
        add_vec(0, 4, 1, 2, 3, 4, 10, 0);
        add_vec(1, 4, 10, 10, 10, 3, 8, 0);
        add_vec(1, 4, -1, 0, 0, 0, -1, 0);
        add_vec(1, 4, 100, 100, 100, 100, 100, 0);
        add_vec(1, 4, 60000, 60000, 5000, 5000, 32500, 0);
        add_vec(2, 1, 5, 0, 0, 0, 5, 0);
        add_vec(2, 1, 40000, 0, 0, 0, 32767, 1);
        add_vec(2, 1, -40000, 0, 0, 0, -32768, 1);
        add_vec(2, 1, -7, 0, 0, 0, -7, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            push_exp(vecs[i].u, {vecs[i].es, OW'(vecs[i].ed)});
            send(vecs[i].u, vecs[i].p0);
            if (vecs[i].n > 1) begin
                send(vecs[i].u, vecs[i].p1);
                send(vecs[i].u, vecs[i].p2);
                send(vecs[i].u, vecs[i].p3);
            end
        end
        tick();
        tick();

        // Latency: result appears exactly one cycle after the 4th term
        push_exp(0, {1'b0, 16'd80});
        send(0, 100);
        send(0, -50);
        send(0, 25);
        chk("lat_before_final", out_valid[0], 0);
        send(0, 5);
        chk("lat_after_final", out_valid[0], 1);
        tick();
        chk("lat_single_cycle", out_valid[0], 0);

        // Backpressure: result held, input refused, junk ignored
        out_ready[0] = 1'b0;
        push_exp(0, {1'b0, 16'd10});
        send(0, 1);
        send(0, 2);
        send(0, 3);
        send(0, 4);
        prod_data[0] = PW'(999);
        prod_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_prod_ready_low", prod_ready[0], 0);
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_out_data_stable", out_data[0], 10);
            chk("bp_state_full", dbg_state[0], 1);
        end
        tick();
        chk("bp_cnt_unchanged", dbg_cnt[0], 0);
        prod_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        #1;
        chk("bp_release_prod_ready", prod_ready[0], 1);
        tick();
        chk("bp_drained", out_valid[0], 0);

        // Reset discards a pending result
        out_ready[0] = 1'b0;
        send(0, 3);
        send(0, 3);
        send(0, 3);
        send(0, 3);
        chk("pend_before_rst", out_valid[0], 1);
        rst = 1'b1;
        #1;
        chk("pend_rst_valid", out_valid[0], 0);
        chk("pend_rst_data", out_data[0], 0);
        chk("pend_rst_ready", prod_ready[0], 1);
        out_ready[0] = 1'b1;
        tick();
        rst = 1'b0;

        // Reset mid-vector discards partial sum
        send(0, 7);
        send(0, 9);
        chk("mid_cnt_before_rst", dbg_cnt[0], 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", dbg_cnt[0], 0);
        tick();
        rst = 1'b0;
        push_exp(0, {1'b0, 16'd4});
        send(0, 1);
        send(0, 1);
        send(0, 1);
        send(0, 1);
        tick();
        tick();

        // Back-to-back throughput
        pop_cyc0.delete();
        push_exp(0, {1'b0, 16'd8});
        push_exp(0, {1'b0, 16'd8});
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(0, 2);
        chk("tp_cycles_for_8_terms", cyc - c0, 8);
        tick();
        tick();
        chk("tp_result_count", pop_cyc0.size(), 2);
        if (pop_cyc0.size() == 2) chk("tp_result_spacing", pop_cyc0[1] - pop_cyc0[0], 4);

        // Random vectors with random downstream backpressure
        bp_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            int u;
            u = k % 2;
            sh = (u == 0) ? 0 : 2;
            sum = 0;
            for (int t = 0; t < 4; t++) begin
                if ($urandom_range(0, 1) == 1) pv = int'($urandom_range(0, 1048575)) - 524288;
                else pv = int'($urandom_range(0, 20000)) - 10000;
                sum += pv;
                if (t == 3) push_exp(u, model(sum, sh));
                send(u, pv);
            end
        end
        bp_en = 1'b0;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;

        // Drain
        begin
            int guard;
            guard = 0;
            while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && guard < 200) begin
                tick();
                guard++;
            end
            chk("drain_pending", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
